// File: rtl/keypad_add_ctrl.sv
// keypad_add_ctrl
//   Turns keypad codes into two operands of DIGITS nibbles each and runs the
//   adder through a start/done handshake. The returned sum is latched for the
//   display.
//
// Optional feature macro: KEY_DEBOUNCE_EN
//   Defined   : a key is accepted only after sample has been stable for
//               DEBOUNCE_CYCLES consecutive cycles.
//   Undefined : a key event is any change of sample to a code other than
//               KEY_NONE.
//
// Ports
//   clk        system clock, posedge
//   rst_n      synchronous reset, active low
//   sample     keypad code: 0-9 digit, A plus, B clear, C equals,
//              D/E unused, F none
//   op_a/op_b  operands to adder
//   start      one-cycle pulse on the first S_RUN cycle
//   done       adder result valid; sum is sampled on this cycle
//   sum        adder result
//   disp       value to display (selected by state)
//   digit_cnt  nibbles entered into the current operand
//   debug      current state encoding
module keypad_add_ctrl #(
  parameter int unsigned DIGITS          = 3,
  parameter logic [3:0]  KEY_NONE        = 4'hF,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   sample,
  output logic [4*DIGITS-1:0]          op_a,
  output logic [4*DIGITS-1:0]          op_b,
  output logic                         start,
  input  logic                         done,
  input  logic [4*DIGITS-1:0]          sum,
  output logic [4*DIGITS-1:0]          disp,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic [1:0]                   debug
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_EQ    = 4'hC;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_RUN  = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t          state_q, state_n;
  logic [W-1:0]    op_a_n, op_b_n, result_q, result_n;
  logic [CW-1:0]   cnt_n;
  logic            start_n;

  logic            evt;
  logic [3:0]      key;
  logic            is_digit;

  // ---------------------------------------------------------------------
  // Key event detection
  // ---------------------------------------------------------------------
`ifdef KEY_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]      cand_q, accepted_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            settled;

  // db_cnt_q counts the cycles sample has already matched cand_q, including
  // the cycle on which it was captured; the DEBOUNCE_CYCLES-th matching
  // cycle promotes the candidate to the accepted code.
  assign settled = (sample == cand_q) &&
                   (db_cnt_q >= DB_W'(DEBOUNCE_CYCLES - 1));
  assign evt     = settled && (cand_q != accepted_q) && (cand_q != KEY_NONE);
  assign key     = cand_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q     <= KEY_NONE;
      accepted_q <= KEY_NONE;
      db_cnt_q   <= '0;
    end else begin
      if (sample != cand_q) begin
        cand_q   <= sample;
        db_cnt_q <= DB_W'(1);
      end else if (db_cnt_q < DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
      if (settled) begin
        accepted_q <= cand_q;
      end
    end
  end
`else
  logic [3:0] sample_q;

  assign evt = (sample != sample_q) && (sample != KEY_NONE);
  assign key = sample;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q <= KEY_NONE;
    end else begin
      sample_q <= sample;
    end
  end
`endif

  assign is_digit = (key <= 4'd9);

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_A;
      op_a      <= '0;
      op_b      <= '0;
      result_q  <= '0;
      digit_cnt <= '0;
      start     <= 1'b0;
    end else begin
      state_q   <= state_n;
      op_a      <= op_a_n;
      op_b      <= op_b_n;
      result_q  <= result_n;
      digit_cnt <= cnt_n;
      start     <= start_n;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_n  = state_q;
    op_a_n   = op_a;
    op_b_n   = op_b;
    result_n = result_q;
    cnt_n    = digit_cnt;
    start_n  = 1'b0;

    unique case (state_q)
      S_A, S_B: begin
        if (evt) begin
          if (is_digit) begin
            // Digits past DIGITS are dropped, no wrap.
            if (digit_cnt < CW'(DIGITS)) begin
              if (state_q == S_A) begin
                op_a_n = {op_a[W-5:0], key};
              end else begin
                op_b_n = {op_b[W-5:0], key};
              end
              cnt_n = digit_cnt + CW'(1);
            end
          end else if (key == KEY_PLUS && state_q == S_A) begin
            state_n = S_B;
            cnt_n   = '0;
          end else if (key == KEY_EQ && state_q == S_B) begin
            state_n = S_RUN;
            start_n = 1'b1;
          end else if (key == KEY_CLEAR) begin
            state_n = S_A;
            op_a_n  = '0;
            op_b_n  = '0;
            cnt_n   = '0;
          end
        end
      end

      S_RUN: begin
        // Keys are ignored here; done also wins over a coincident key.
        if (done) begin
          result_n = sum;
          state_n  = S_SHOW;
          cnt_n    = '0;
        end
      end

      S_SHOW: begin
        if (evt) begin
          if (is_digit) begin
            state_n = S_A;
            op_a_n  = {{(W-4){1'b0}}, key};
            op_b_n  = '0;
            cnt_n   = CW'(1);
          end else if (key == KEY_CLEAR) begin
            state_n = S_A;
            op_a_n  = '0;
            op_b_n  = '0;
            cnt_n   = '0;
          end
        end
      end

      default: state_n = S_A;
    endcase
  end

  // ---------------------------------------------------------------------
  // Display select
  // ---------------------------------------------------------------------
  always_comb begin
    disp = '0;
    unique case (state_q)
      S_A:     disp = op_a;
      S_B:     disp = op_b;
      S_RUN:   disp = op_b;
      S_SHOW:  disp = result_q;
      default: disp = '0;
    endcase
  end

  assign debug = state_q;

endmodule

// File: tb/tb_keypad_add_ctrl.sv
module tb_keypad_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sample;
  logic [11:0] op_a, op_b;
  logic        start;
  logic        done;
  logic [11:0] sum;
  logic [11:0] disp;
  logic [1:0]  digit_cnt;
  logic [1:0]  debug;

  keypad_add_ctrl #(
    .DIGITS(3),
    .KEY_NONE(4'hF),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample(sample),
    .op_a(op_a),
    .op_b(op_b),
    .start(start),
    .done(done),
    .sum(sum),
    .disp(disp),
    .digit_cnt(digit_cnt),
    .debug(debug)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned start_pulses = 0;
  logic        start_seen;

  always @(negedge clk) if (start === 1'b1) start_pulses++;

  typedef struct {
    string       tag;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic push(input string tag, input logic [11:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [11:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val && e.tag == tag) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h (queued %s)", tag, obs, e.val, e.tag);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    sample = k;
    tick();
    sample = 4'hF;
    tick();
  endtask

  // Drive '=' and wait (bounded) for the start pulse.
  task automatic equals_wait_start();
    start_seen = 1'b0;
    sample = 4'hC;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (start === 1'b1) begin
        start_seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sample = 4'hF;
    done   = 1'b0;
    sum    = '0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;

    // Reset state
    push("rst_state", 12'h0); push("rst_op_a", 12'h0); push("rst_op_b", 12'h0);
    push("rst_cnt", 12'h0);   push("rst_start", 12'h0); push("rst_disp", 12'h0);
    check("rst_state", 12'(debug)); check("rst_op_a", op_a); check("rst_op_b", op_b);
    check("rst_cnt", 12'(digit_cnt)); check("rst_start", 12'(start)); check("rst_disp", disp);

    // Entry and add
    push("a_123", 12'h123); push("a_cnt3", 12'h3); push("a_disp", 12'h123);
    press(4'h1); press(4'h2); press(4'h3);
    check("a_123", op_a); check("a_cnt3", 12'(digit_cnt)); check("a_disp", disp);

    push("plus_state", 12'h1); push("plus_cnt", 12'h0);
    press(4'hA);
    check("plus_state", 12'(debug)); check("plus_cnt", 12'(digit_cnt));

    push("b_045", 12'h045); push("b_disp", 12'h045);
    press(4'h0); press(4'h4); press(4'h5);
    check("b_045", op_b); check("b_disp", disp);

    push("eq_start", 12'h1); push("eq_state", 12'h2); push("run_op_a", 12'h123);
    equals_wait_start();
    check("eq_start", 12'(start_seen)); check("eq_state", 12'(debug)); check("run_op_a", op_a);
    push("start_low", 12'h0); push("run_hold", 12'h2);
    sample = 4'hF;
    tick();
    check("start_low", 12'(start)); check("run_hold", 12'(debug));

    push("show_state", 12'h3); push("show_disp", 12'h168); push("show_cnt", 12'h0);
    push("pulses_1", 12'h1);
    done = 1'b1; sum = 12'h168;
    tick();
    done = 1'b0;
    check("show_state", 12'(debug)); check("show_disp", disp); check("show_cnt", 12'(digit_cnt));
    check("pulses_1", 12'(start_pulses));

    // Clear from S_SHOW, then overflow digits
    push("clr_state", 12'h0); push("clr_op_a", 12'h0);
    press(4'hB);
    check("clr_state", 12'(debug)); check("clr_op_a", op_a);
    push("ovf_op_a", 12'h987); push("ovf_cnt", 12'h3);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    check("ovf_op_a", op_a); check("ovf_cnt", 12'(digit_cnt));

    // Held key then direct key-to-key change
    press(4'hB);
    push("held_op_a", 12'h057); push("held_cnt", 12'h2);
    sample = 4'h5;
    repeat (20) tick();
    sample = 4'h7;
    tick();
    sample = 4'hF;
    tick();
    check("held_op_a", op_a); check("held_cnt", 12'(digit_cnt));

    // Ignored D, clear from S_B
    press(4'hB);
    press(4'h4);
    press(4'hA);
    push("b_012", 12'h012); push("b_cnt2", 12'h2);
    press(4'h1); press(4'h2);
    check("b_012", op_b); check("b_cnt2", 12'(digit_cnt));
    push("d_state", 12'h1); push("d_op_b", 12'h012); push("d_cnt", 12'h2);
    press(4'hD);
    check("d_state", 12'(debug)); check("d_op_b", op_b); check("d_cnt", 12'(digit_cnt));
    push("bclr_state", 12'h0); push("bclr_op_a", 12'h0); push("bclr_op_b", 12'h0);
    press(4'hB);
    check("bclr_state", 12'(debug)); check("bclr_op_a", op_a); check("bclr_op_b", op_b);

    // Clear ignored in S_RUN
    press(4'h1); press(4'hA); press(4'h2);
    push("eq2_start", 12'h1);
    equals_wait_start();
    check("eq2_start", 12'(start_seen));
    sample = 4'hF;
    tick();
    push("runclr_state", 12'h2); push("runclr_op_a", 12'h001);
    push("runclr_op_b", 12'h002); push("runclr_disp", 12'h002);
    press(4'hB);
    check("runclr_state", 12'(debug)); check("runclr_op_a", op_a);
    check("runclr_op_b", op_b); check("runclr_disp", disp);

    // Key and done on the same cycle: done wins, key is not re-seen
    push("sim_state", 12'h3); push("sim_disp", 12'h003); push("sim_op_a", 12'h001);
    sample = 4'h5; done = 1'b1; sum = 12'h003;
    tick();
    done = 1'b0;
    check("sim_state", 12'(debug)); check("sim_disp", disp); check("sim_op_a", op_a);
    push("sim_hold", 12'h3);
    tick();
    check("sim_hold", 12'(debug));
    sample = 4'hF;
    tick();

    // done outside S_RUN is ignored
    push("late_done_disp", 12'h003); push("late_done_state", 12'h3);
    done = 1'b1; sum = 12'hFFF;
    tick();
    done = 1'b0;
    check("late_done_disp", disp); check("late_done_state", 12'(debug));

    // Digit in S_SHOW starts a new operand A
    push("sdig_state", 12'h0); push("sdig_op_a", 12'h006);
    push("sdig_op_b", 12'h0);  push("sdig_cnt", 12'h1);
    press(4'h6);
    check("sdig_state", 12'(debug)); check("sdig_op_a", op_a);
    check("sdig_op_b", op_b); check("sdig_cnt", 12'(digit_cnt));

    // Reset mid-run, then a stray done
    press(4'hA); press(4'h2);
    push("eq3_start", 12'h1);
    equals_wait_start();
    check("eq3_start", 12'(start_seen));
    sample = 4'hF;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push("mrst_state", 12'h0); push("mrst_op_a", 12'h0); push("mrst_op_b", 12'h0);
    push("mrst_disp", 12'h0);  push("mrst_start", 12'h0);
    done = 1'b1; sum = 12'hABC;
    tick();
    done = 1'b0;
    check("mrst_state", 12'(debug)); check("mrst_op_a", op_a); check("mrst_op_b", op_b);
    check("mrst_disp", disp); check("mrst_start", 12'(start));
    push("mrst_hold", 12'h0); push("pulses_3", 12'h3);
    tick();
    check("mrst_hold", 12'(debug)); check("pulses_3", 12'(start_pulses));

    // Every queued expectation must have been consumed
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain: observed %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
